// File: rtl/glitch_pkg.sv
// Shared types and default widths for the clock-glitch pulse sequencer.
package glitch_pkg;

    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned REP_W_DEF  = 8;
    localparam int unsigned MISS_W_DEF = 8;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_REARM  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
        GAP   = 3'd4
    } glitch_state_e;

endpackage : glitch_pkg

// File: rtl/glitch_timer.sv
// Loadable down counter shared by the delay, pulse-width and gap phases.
module glitch_timer
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_c_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load wins over decrement; the counter parks at zero and never wraps.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_c_o = (count_q == CNT_W'(1));

endmodule : glitch_timer

// File: rtl/glitch_sequencer.sv
// Trigger-driven glitch pulse sequencer: delay, then count pulses of width
// separated by gap, gating the XOR glitch clock through glitch_en.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned REP_W  = REP_W_DEF,
    parameter int unsigned MISS_W = MISS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_gap,
    input  logic [REP_W-1:0]  cfg_count,
    input  logic              cfg_mode,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    output logic              glitch_en,
    output logic              armed,
    output logic              busy,
    output logic              done,
    output logic [REP_W-1:0]  pulse_idx,
    output logic [MISS_W-1:0] missed_trig
);

    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    glitch_state_e     state_q, state_d;
    logic              trig_q;
    logic [CNT_W-1:0]  dly_q, dly_d;
    logic [CNT_W-1:0]  wid_q, wid_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [REP_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [REP_W-1:0]  pulse_idx_q, pulse_idx_d;
    logic [MISS_W-1:0] missed_q, missed_d;
    logic              glitch_en_q, glitch_en_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              trig_edge;
    logic              busy_state;
    logic              last_pulse;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;
    logic              timer_en;
    logic              timer_expire;

    assign trig_edge  = trigger & ~trig_q;
    assign busy_state = (state_q == DELAY) || (state_q == PULSE) || (state_q == GAP);
    assign last_pulse = (pulse_idx_q == (cnt_q - REP_W'(1)));

    glitch_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .en_i       (timer_en),
        .expire_c_o (timer_expire)
    );

    // Next-state, shadow-config and registered-output decode.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        wid_d       = wid_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        pulse_idx_d = pulse_idx_q;
        missed_d    = missed_q;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_val   = wid_q;
        timer_en    = 1'b0;

        if (trig_edge && busy_state && (missed_q != MISS_MAX)) begin
            missed_d = missed_q + MISS_W'(1);
        end

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        dly_d   = cfg_delay;
                        wid_d   = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
                        gap_d   = (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
                        cnt_d   = (cfg_count == '0) ? REP_W'(1) : cfg_count;
                        mode_d  = cfg_mode;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        pulse_idx_d = '0;
                        timer_load  = 1'b1;
                        if (dly_q == '0) begin
                            timer_val = wid_q;
                            state_d   = PULSE;
                        end else begin
                            timer_val = dly_q;
                            state_d   = DELAY;
                        end
                    end
                end
                DELAY: begin
                    timer_en = 1'b1;
                    if (timer_expire) begin
                        timer_load = 1'b1;
                        timer_val  = wid_q;
                        state_d    = PULSE;
                    end
                end
                PULSE: begin
                    timer_en = 1'b1;
                    if (timer_expire) begin
                        if (last_pulse) begin
                            done_d  = 1'b1;
                            state_d = (mode_q == MODE_REARM) ? ARMED : IDLE;
                        end else begin
                            pulse_idx_d = pulse_idx_q + REP_W'(1);
                            timer_load  = 1'b1;
                            timer_val   = gap_q;
                            state_d     = GAP;
                        end
                    end
                end
                GAP: begin
                    timer_en = 1'b1;
                    if (timer_expire) begin
                        timer_load = 1'b1;
                        timer_val  = wid_q;
                        state_d    = PULSE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        glitch_en_d = (state_d == PULSE);
        armed_d     = (state_d == ARMED);
        busy_d      = (state_d == DELAY) || (state_d == PULSE) || (state_d == GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            trig_q      <= 1'b0;
            dly_q       <= '0;
            wid_q       <= CNT_W'(1);
            gap_q       <= CNT_W'(1);
            cnt_q       <= REP_W'(1);
            mode_q      <= MODE_SINGLE;
            pulse_idx_q <= '0;
            missed_q    <= '0;
            glitch_en_q <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trigger;
            dly_q       <= dly_d;
            wid_q       <= wid_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pulse_idx_q <= pulse_idx_d;
            missed_q    <= missed_d;
            glitch_en_q <= glitch_en_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign glitch_en   = glitch_en_q;
    assign armed       = armed_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_idx   = pulse_idx_q;
    assign missed_trig = missed_q;

endmodule : glitch_sequencer

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: directed sequences with literal pulse maps,
// then random stimulus against a timeline-arithmetic reference model.
module tb_glitch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_delay, cfg_width, cfg_gap;
    logic [7:0]  cfg_count;
    logic        cfg_mode, arm, trigger, abort;

    logic        glitch_en, armed, busy, done;
    logic [7:0]  pulse_idx, missed_trig;
    logic        glitch_en_b, armed_b, busy_b, done_b;
    logic [7:0]  pulse_idx_b;
    logic [1:0]  missed_trig_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glitch_sequencer u_dut (
        .clk(clk), .reset(reset), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_mode(cfg_mode), .arm(arm),
        .trigger(trigger), .abort(abort), .glitch_en(glitch_en), .armed(armed),
        .busy(busy), .done(done), .pulse_idx(pulse_idx), .missed_trig(missed_trig)
    );

    glitch_sequencer #(.MISS_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_gap(cfg_gap), .cfg_count(cfg_count), .cfg_mode(cfg_mode), .arm(arm),
        .trigger(trigger), .abort(abort), .glitch_en(glitch_en_b), .armed(armed_b),
        .busy(busy_b), .done(done_b), .pulse_idx(pulse_idx_b), .missed_trig(missed_trig_b)
    );

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a sequence is a timeline indexed by k = cycles since the edge.
    int     m_st;      // 0 idle, 1 armed, 2 running
    longint m_k;
    longint sd, sw, sg, sn;
    bit     smode;
    int     m_idx, m_miss_a, m_miss_b;
    bit     m_tprev, m_valid;
    bit     exp_glitch, exp_armed, exp_busy, exp_done;

    function automatic longint seq_len();
        return sd + sn * sw + (sn - 1) * sg;
    endfunction

    function automatic bit in_pulse(input longint k);
        for (longint p = 0; p < sn; p++) begin
            if (k >= sd + 1 + p * (sw + sg) && k < sd + 1 + p * (sw + sg) + sw) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int idx_at(input longint k);
        int n = 0;
        for (longint p = 0; p < sn - 1; p++) begin
            if (sd + p * (sw + sg) + sw + 1 <= k) n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        bit te, fin;
        te  = trigger && !m_tprev;
        fin = 1'b0;
        if (reset) begin
            m_st = 0; m_idx = 0; m_miss_a = 0; m_miss_b = 0; m_tprev = 0; m_k = 0;
            m_valid = 1'b1;
        end else begin
            m_tprev = trigger;
            if (te && m_st == 2) begin
                if (m_miss_a < 255) m_miss_a++;
                if (m_miss_b < 3) m_miss_b++;
            end
            if (abort) begin
                m_st = 0;
            end else if (m_st == 0) begin
                if (arm) begin
                    sd    = longint'(cfg_delay);
                    sw    = (cfg_width == 0) ? 1 : longint'(cfg_width);
                    sg    = (cfg_gap == 0) ? 1 : longint'(cfg_gap);
                    sn    = (cfg_count == 0) ? 1 : longint'(cfg_count);
                    smode = cfg_mode;
                    m_st  = 1;
                end
            end else if (m_st == 1) begin
                if (te) begin
                    m_st = 2;
                    m_k  = 1;
                end
            end else begin
                m_k++;
                if (m_k > seq_len()) begin
                    m_st = smode ? 1 : 0;
                    fin  = 1'b1;
                end
            end
        end
        if (m_st == 2) m_idx = idx_at(m_k);
        exp_glitch = (m_st == 2) && in_pulse(m_k);
        exp_busy   = (m_st == 2);
        exp_armed  = (m_st == 1);
        exp_done   = fin;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("glitch_en", glitch_en, exp_glitch);
            chk("armed", armed, exp_armed);
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("pulse_idx", pulse_idx, m_idx);
            chk("missed_trig", missed_trig, m_miss_a);
            chk("b_glitch_en", glitch_en_b, exp_glitch);
            chk("b_armed", armed_b, exp_armed);
            chk("b_busy", busy_b, exp_busy);
            chk("b_done", done_b, exp_done);
            chk("b_pulse_idx", pulse_idx_b, m_idx);
            chk("b_missed_trig", missed_trig_b, m_miss_b);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_arm(input int d, input int w, input int g, input int n, input bit md);
        @(negedge clk);
        cfg_delay = 16'(d); cfg_width = 16'(w); cfg_gap = 16'(g);
        cfg_count = 8'(n);  cfg_mode  = md;     arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Cycle k of the run: sample outputs, then drive trigger/arm/abort for cycle k.
    task automatic run_seq(input logic [31:0] tm, input logic [31:0] am, input logic [31:0] bm,
                           input int n, output logic [31:0] gm, output logic [31:0] dm);
        gm = '0;
        dm = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            gm[k]   = glitch_en;
            dm[k]   = done;
            trigger = tm[k];
            arm     = am[k];
            abort   = bm[k];
        end
        trigger = 1'b0; arm = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gm, dm;
        reset = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
        cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0; cfg_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_glitch_en", glitch_en, 0);
        chk("reset_pulse_idx", pulse_idx, 0);
        chk("reset_missed", missed_trig, 0);
        reset = 1'b0;

        // delay 5, width 3, gap 2, two pulses, single-shot
        do_arm(5, 3, 2, 2, 0);
        run_seq(32'h1, 32'h0, 32'h0, 17, gm, dm);
        chk("t1_glitch_map", gm, 32'h0000_39C0);
        chk("t1_done_map", dm, 32'h0000_4000);
        @(negedge clk);
        chk("t1_idle_armed", armed, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_pulse_idx", pulse_idx, 1);

        // zero delay, zero width/count substituted by one
        do_arm(0, 0, 7, 0, 0);
        run_seq(32'h1, 32'h0, 32'h0, 5, gm, dm);
        chk("t2_glitch_map", gm, 32'h2);
        chk("t2_done_map", dm, 32'h4);

        // auto-rearm: second edge repeats the sequence without arm
        do_arm(2, 2, 1, 1, 1);
        run_seq(32'h1, 32'h0, 32'h0, 8, gm, dm);
        chk("t3_glitch_map_1", gm, 32'h18);
        chk("t3_done_map_1", dm, 32'h20);
        chk("t3_rearmed", armed, 1);
        run_seq(32'h1, 32'h0, 32'h0, 8, gm, dm);
        chk("t3_glitch_map_2", gm, 32'h18);
        chk("t3_done_map_2", dm, 32'h20);

        // missed triggers during a long pulse; 2-bit counter saturates
        do_reset();
        do_arm(1, 20, 1, 1, 0);
        run_seq(32'h0A9, 32'h0, 32'h0, 24, gm, dm);
        chk("t4_glitch_map", gm, 32'h003F_FFFC);
        chk("t4_done_map", dm, 32'h0040_0000);
        chk("t4_missed_3", missed_trig, 3);
        do_arm(1, 20, 1, 1, 0);
        run_seq(32'hAA9, 32'h0, 32'h0, 24, gm, dm);
        chk("t4_glitch_map_2", gm, 32'h003F_FFFC);
        chk("t4_missed_8", missed_trig, 8);
        chk("t4_missed_sat", missed_trig_b, 3);

        // abort in the second pulse cycle, then a normal sequence
        do_arm(1, 5, 1, 2, 0);
        run_seq(32'h1, 32'h0, 32'h8, 12, gm, dm);
        chk("t5_glitch_map", gm, 32'hC);
        chk("t5_done_map", dm, 32'h0);
        chk("t5_idle_armed", armed, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_missed_kept", missed_trig, 8);
        do_arm(5, 3, 2, 2, 0);
        run_seq(32'h1, 32'h0, 32'h0, 17, gm, dm);
        chk("t5_glitch_map_2", gm, 32'h0000_39C0);
        chk("t5_done_map_2", dm, 32'h0000_4000);

        // arm and edge together: arm wins; later cfg change is ignored
        cfg_delay = 16'd3; cfg_width = 16'd1; cfg_gap = 16'd1; cfg_count = 8'd1; cfg_mode = 1'b0;
        run_seq(32'h1, 32'h1, 32'h0, 6, gm, dm);
        chk("t6_no_pulse", gm, 32'h0);
        chk("t6_armed", armed, 1);
        cfg_delay = 16'd7;
        run_seq(32'h1, 32'h0, 32'h0, 8, gm, dm);
        chk("t6_glitch_map", gm, 32'h10);
        chk("t6_done_map", dm, 32'h20);

        // random traffic, checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 399) == 0);
            abort     = ($urandom_range(0, 79) == 0);
            arm       = ($urandom_range(0, 5) == 0);
            trigger   = ($urandom_range(0, 3) == 0);
            cfg_delay = 16'($urandom_range(0, 6));
            cfg_width = 16'($urandom_range(0, 4));
            cfg_gap   = 16'($urandom_range(0, 3));
            cfg_count = 8'($urandom_range(0, 3));
            cfg_mode  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        reset = 1'b0; abort = 1'b0; arm = 1'b0; trigger = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_glitch_sequencer
